// File: rtl/risc16_mem_pkg.sv
// Shared data-memory definitions: default widths, access-type encoding and a
// helper that sizes counters able to hold 0..max inclusive.
// Pure declarations; no logic, no latency, no backpressure.
package risc16_mem_pkg;

  localparam int unsigned DEF_WORD_LEN = 16;
  localparam int unsigned DEF_ADDR_LEN = 10;

  // Encoding of the *_we inputs.
  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_e;

  // Width of a counter that must represent 0..max_val. Never returns 0 so a
  // zero bound still yields a legal one-bit register.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val == 0) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the debug port was denied.
// State updates on posedge; o_at_max is a direct decode of the register.
// No handshake: clear dominates increment, increment stops at p_MAX.
module arb_starve_ctr
  import risc16_mem_pkg::*;
#(
  parameter int unsigned p_MAX = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int unsigned CW = cnt_width(p_MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_at_max = (cnt_q == CW'(p_MAX));

  // Next count: clear wins, otherwise count up until the bound is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && !o_at_max) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_data_arbiter.sv
// Shares one single-ported data memory between the core MEM stage and debug.
// Core access and grant are combinational (0 cycles); debug read data 1 cycle after grant.
// Losing core is stalled via o_core_stall; debug holds its request until o_dbg_gnt.
module mem_data_arbiter
  import risc16_mem_pkg::*;
#(
  parameter int unsigned p_WORD_LEN = DEF_WORD_LEN,
  parameter int unsigned p_ADDR_LEN = DEF_ADDR_LEN,
  parameter int unsigned p_MAX_WAIT = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [p_ADDR_LEN-1:0] i_core_addr,
  input  logic [p_WORD_LEN-1:0] i_core_wr_data,
  output logic [p_WORD_LEN-1:0] o_core_rd_data,
  output logic                  o_core_stall,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [p_ADDR_LEN-1:0] i_dbg_addr,
  input  logic [p_WORD_LEN-1:0] i_dbg_wr_data,
  input  logic                  i_dbg_halt,
  output logic                  o_dbg_gnt,
  output logic                  o_dbg_rvalid,
  output logic [p_WORD_LEN-1:0] o_dbg_rd_data,
  output logic                  o_mem_wr_en,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data
);

  logic                  core_gnt;
  logic                  dbg_gnt;
  logic                  wait_at_max;
  acc_e                  dbg_acc;
  logic                  dbg_rvalid_q;
  logic                  dbg_rvalid_d;
  logic [p_WORD_LEN-1:0] dbg_rd_data_q;
  logic [p_WORD_LEN-1:0] dbg_rd_data_d;

  assign dbg_acc = acc_e'(i_dbg_we);

  // Debug wins under halt, when the core is idle, or once it has waited its limit.
  always_comb begin
    dbg_gnt  = i_dbg_req & (i_dbg_halt | ~i_core_req | wait_at_max);
    core_gnt = i_core_req & ~dbg_gnt;
  end

  // Counts denied debug cycles; any grant or a dropped request restarts it.
  arb_starve_ctr #(
    .p_MAX (p_MAX_WAIT)
  ) u_starve_ctr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_inc    (i_dbg_req & ~dbg_gnt),
    .i_clr    (dbg_gnt | ~i_dbg_req),
    .o_at_max (wait_at_max)
  );

  // Memory port mux: the granted requester drives it, otherwise all zeros.
  always_comb begin
    o_mem_wr_en   = 1'b0;
    o_mem_addr    = '0;
    o_mem_wr_data = '0;
    if (dbg_gnt) begin
      o_mem_wr_en   = (dbg_acc == ACC_WRITE);
      o_mem_addr    = i_dbg_addr;
      o_mem_wr_data = i_dbg_wr_data;
    end else if (core_gnt) begin
      o_mem_wr_en   = i_core_we;
      o_mem_addr    = i_core_addr;
      o_mem_wr_data = i_core_wr_data;
    end
  end

  assign o_core_rd_data = i_mem_rd_data;
  assign o_core_stall   = i_core_req & ~core_gnt;
  assign o_dbg_gnt      = dbg_gnt;

  // Capture memory data at the end of a granted debug read; pulse valid once.
  always_comb begin
    dbg_rvalid_d  = 1'b0;
    dbg_rd_data_d = dbg_rd_data_q;
    if (dbg_gnt && (dbg_acc == ACC_READ)) begin
      dbg_rvalid_d  = 1'b1;
      dbg_rd_data_d = i_mem_rd_data;
    end
  end

  // Debug read-return registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dbg_rvalid_q  <= 1'b0;
      dbg_rd_data_q <= '0;
    end else begin
      dbg_rvalid_q  <= dbg_rvalid_d;
      dbg_rd_data_q <= dbg_rd_data_d;
    end
  end

  assign o_dbg_rvalid  = dbg_rvalid_q;
  assign o_dbg_rd_data = dbg_rd_data_q;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Bench for mem_data_arbiter: directed scenarios followed by random traffic.
// Expected values come from a priority/wait model and a reference memory image.
// A behavioural single-port memory is attached to the DUT's memory port.
module tb_mem_data_arbiter;

  localparam int W  = 16;
  localparam int A  = 10;
  localparam int MW = 3;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_core_req;
  logic         i_core_we;
  logic [A-1:0] i_core_addr;
  logic [W-1:0] i_core_wr_data;
  logic [W-1:0] o_core_rd_data;
  logic         o_core_stall;
  logic         i_dbg_req;
  logic         i_dbg_we;
  logic [A-1:0] i_dbg_addr;
  logic [W-1:0] i_dbg_wr_data;
  logic         i_dbg_halt;
  logic         o_dbg_gnt;
  logic         o_dbg_rvalid;
  logic [W-1:0] o_dbg_rd_data;
  logic         o_mem_wr_en;
  logic [A-1:0] o_mem_addr;
  logic [W-1:0] o_mem_wr_data;
  logic [W-1:0] i_mem_rd_data;

  mem_data_arbiter #(
    .p_WORD_LEN (W),
    .p_ADDR_LEN (A),
    .p_MAX_WAIT (MW)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_core_req     (i_core_req),
    .i_core_we      (i_core_we),
    .i_core_addr    (i_core_addr),
    .i_core_wr_data (i_core_wr_data),
    .o_core_rd_data (o_core_rd_data),
    .o_core_stall   (o_core_stall),
    .i_dbg_req      (i_dbg_req),
    .i_dbg_we       (i_dbg_we),
    .i_dbg_addr     (i_dbg_addr),
    .i_dbg_wr_data  (i_dbg_wr_data),
    .i_dbg_halt     (i_dbg_halt),
    .o_dbg_gnt      (o_dbg_gnt),
    .o_dbg_rvalid   (o_dbg_rvalid),
    .o_dbg_rd_data  (o_dbg_rd_data),
    .o_mem_wr_en    (o_mem_wr_en),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wr_data  (o_mem_wr_data),
    .i_mem_rd_data  (i_mem_rd_data)
  );

  // Physical memory attached to the arbiter.
  logic [W-1:0] mem [0:(1<<A)-1];
  assign i_mem_rd_data = mem[o_mem_addr];
  always @(posedge i_clk) begin
    if (o_mem_wr_en) mem[o_mem_addr] <= o_mem_wr_data;
  end

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Reference model state.
  logic [W-1:0] ref_mem [0:(1<<A)-1];
  int           m_wait;
  logic         m_rvalid;
  logic [W-1:0] m_rdata;
  logic         last_dgnt;
  int           checks;
  int           errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational and registered outputs, advance model.
  task automatic step(input logic cr, input logic cw, input logic [A-1:0] ca,
                      input logic [W-1:0] cd, input logic dr, input logic dw,
                      input logic [A-1:0] da, input logic [W-1:0] dd, input logic h);
    logic         dwin;
    logic         cgnt;
    logic         ewe;
    logic [A-1:0] ea;
    logic [W-1:0] ed;
    i_core_req = cr; i_core_we = cw; i_core_addr = ca; i_core_wr_data = cd;
    i_dbg_req = dr; i_dbg_we = dw; i_dbg_addr = da; i_dbg_wr_data = dd; i_dbg_halt = h;
    @(negedge i_clk);
    dwin = dr && (h || !cr || m_wait >= MW);
    cgnt = cr && !dwin;
    ewe = 1'b0; ea = '0; ed = '0;
    if (dwin) begin
      ewe = dw; ea = da; ed = dd;
    end else if (cgnt) begin
      ewe = cw; ea = ca; ed = cd;
    end
    chk("dbg_gnt",     32'(o_dbg_gnt),     32'(dwin));
    chk("core_stall",  32'(o_core_stall),  32'(cr && !cgnt));
    chk("mem_wr_en",   32'(o_mem_wr_en),   32'(ewe));
    chk("mem_addr",    32'(o_mem_addr),    32'(ea));
    chk("mem_wr_data", 32'(o_mem_wr_data), 32'(ed));
    chk("dbg_rvalid",  32'(o_dbg_rvalid),  32'(m_rvalid));
    chk("dbg_rd_data", 32'(o_dbg_rd_data), 32'(m_rdata));
    if (cgnt && !cw) chk("core_rd_data", 32'(o_core_rd_data), 32'(ref_mem[ca]));
    @(posedge i_clk);
    m_rvalid = dwin && !dw;
    if (m_rvalid) m_rdata = ref_mem[da];
    if (dwin && dw) ref_mem[da] = dd;
    if (cgnt && cw) ref_mem[ca] = cd;
    if (dwin || !dr) m_wait = 0;
    else if (m_wait < MW) m_wait = m_wait + 1;
    last_dgnt = dwin;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic model_reset();
    m_wait = 0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  initial begin
    int           n;
    logic         dpend;
    logic         dw;
    logic         halt;
    logic [A-1:0] da;
    logic [W-1:0] dd;
    checks = 0; errors = 0; last_dgnt = 1'b0;
    for (int i = 0; i < (1 << A); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    i_rst_n = 1'b0;
    i_core_req = 0; i_core_we = 0; i_core_addr = '0; i_core_wr_data = '0;
    i_dbg_req = 0; i_dbg_we = 0; i_dbg_addr = '0; i_dbg_wr_data = '0; i_dbg_halt = 0;
    #1;
    chk("rst_rvalid",  32'(o_dbg_rvalid),  32'd0);
    chk("rst_rd_data", 32'(o_dbg_rd_data), 32'd0);
    chk("rst_gnt",     32'(o_dbg_gnt),     32'd0);
    chk("rst_stall",   32'(o_core_stall),  32'd0);
    chk("rst_mem_we",  32'(o_mem_wr_en),   32'd0);
    chk("rst_mem_addr",32'(o_mem_addr),    32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Core only: store then load.
    step(1, 1, 10'h010, 16'hBEEF, 0, 0, '0, '0, 0);
    step(1, 0, 10'h010, 16'h0000, 0, 0, '0, '0, 0);
    chk("core_load_beef", 32'(o_core_rd_data), 32'h0000BEEF);

    // Debug only: write then read, then observe the return.
    step(0, 0, '0, '0, 1, 1, 10'h3FF, 16'h1234, 0);
    step(0, 0, '0, '0, 1, 0, 10'h3FF, 16'h0000, 0);
    idle();
    chk("dbg_read_1234", 32'(o_dbg_rd_data), 32'h00001234);

    // Contention: core busy every cycle, debug read of 0x020.
    step(1, 1, 10'h020, 16'h0C0D, 0, 0, '0, '0, 0);
    n = 0;
    last_dgnt = 1'b0;
    while (!last_dgnt && n < 10) begin
      step(1, 0, 10'($urandom_range(0, 7)), '0, 1, 0, 10'h020, '0, 0);
      if (!last_dgnt) n++;
    end
    chk("starve_denials", 32'(n), 32'(MW));
    step(1, 0, 10'h001, '0, 0, 0, '0, '0, 0);
    chk("contention_rd", 32'(o_dbg_rd_data), 32'h00000C0D);

    // Halt: debug wins every cycle, then normal priority returns.
    for (int i = 0; i < 3; i++) step(1, 0, 10'h002, '0, 1, 0, 10'($urandom_range(0, 7)), '0, 1);
    step(1, 0, 10'h002, '0, 1, 0, 10'h003, '0, 0);
    chk("halt_drop_core_wins", 32'(o_dbg_gnt), 32'd0);
    idle();

    // Same-address race under halt.
    step(1, 1, 10'h005, 16'hAAAA, 1, 1, 10'h005, 16'h5555, 1);
    step(1, 1, 10'h005, 16'hAAAA, 0, 0, '0, '0, 0);
    step(1, 0, 10'h005, '0, 0, 0, '0, '0, 0);
    chk("race_final", 32'(o_core_rd_data), 32'h0000AAAA);

    // Reset with a partially filled wait counter: it must restart from zero.
    step(1, 0, 10'h001, '0, 1, 0, 10'h3FF, '0, 0);
    step(1, 0, 10'h001, '0, 1, 0, 10'h3FF, '0, 0);
    i_rst_n = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    n = 0;
    last_dgnt = 1'b0;
    while (!last_dgnt && n < 10) begin
      step(1, 0, 10'h001, '0, 1, 0, 10'h3FF, '0, 0);
      if (!last_dgnt) n++;
    end
    chk("post_rst_denials", 32'(n), 32'(MW));

    // Reset in the cycle after a debug read grant drops the pending return.
    step(0, 0, '0, '0, 1, 0, 10'h3FF, '0, 0);
    i_rst_n = 1'b0;
    #1;
    chk("rst_drop_rvalid", 32'(o_dbg_rvalid),  32'd0);
    chk("rst_drop_rdata",  32'(o_dbg_rd_data), 32'd0);
    model_reset();
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    idle();

    // Random traffic; the debug requester holds its attributes until granted.
    dpend = 1'b0; dw = 1'b0; da = '0; dd = '0; halt = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1'b1;
        dw = 1'($urandom_range(0, 1));
        da = 10'($urandom_range(0, 7));
        dd = 16'($urandom);
      end
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           10'($urandom_range(0, 7)), 16'($urandom), dpend, dw, da, dd, halt);
      if (last_dgnt) dpend = 1'b0;
    end
    idle();

    // Memory image built through the arbiter must match the reference.
    for (int i = 0; i < 8; i++) chk("mem_image", 32'(mem[i]), 32'(ref_mem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
